csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Parametrised machine-mode CSR file and trap sequencer for the scalar core, the next generation of the CSR unit. It owns the trap-related and counter CSRs. It latches N external interrupt lines and arbitrates exceptions, interrupts and `mret`. It drives a registered, handshaked fetch redirect toward the front end. The block sits beside the commit stage: CSR writes and exceptions arrive from commit, and CSR reads are served to the CSR execution unit.

## Interface
Parameters:
- `NUM_IRQ`, 2: number of external interrupt lines, 1..16; line k maps to mip/mie bit 16+k and cause code 16+k.
- `RETIRE_W`, 2: maximum instructions retired per cycle.
- `VECTORED`, 1: 1 enables mtvec mode 1 (vectored); 0 forces mtvec[1:0] to read 0.
- `RESET_VEC`, 32'h0000_0000: reset value of mtvec.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `irq_i`  in  NUM_IRQ  level interrupt requests
- `irq_allow`  in  1  core is at a precise commit boundary, so an interrupt may be taken
- `commit_pc`  in  32  PC of the oldest uncommitted instruction; becomes mepc on interrupt
- `csr_rd_addr`  in  12  read address
- `csr_rd_data`  out  32  combinational read data
- `csr_we`  in  1  committed CSR write
- `csr_waddr`  in  12  write address
- `csr_wdata`  in  32  write data
- `retire_cnt`  in  $clog2(RETIRE_W+1)  instructions retired this cycle
- `exc_valid`  in  1  committed exception
- `exc_cause`  in  4  exception code
- `exc_pc`  in  32  faulting PC
- `exc_tval`  in  32  trap value
- `mret_i`  in  1  committed mret
- `redirect_valid`  out  1  redirect request
- `redirect_pc`  out  32  target PC
- `redirect_ready`  in  1  front end accepts redirect
- `irq_taken`  out  1  one-cycle pulse on interrupt entry

## Operation
- CSR map:
  - mstatus 0x300: MIE = bit 3, MPIE = bit 7; all other bits read 0.
  - mie 0x304; mtvec 0x305; mscratch 0x340; mepc 0x341 (bits [1:0] read 0); mcause 0x342; mtval 0x343.
  - mip 0x344 is read-only; writes to it are ignored.
  - mcycle/mcycleh at 0xB00/0xB80; minstret/minstreth at 0xB02/0xB82.
  - Unmapped addresses read 0 and ignore writes.
  - mie and mip implement only bits [16+NUM_IRQ-1:16].
- Reads are combinational from current register state; there is no write-to-read bypass.
- mip[16+k] is loaded from irq_i[k] every cycle (one-register latency).
- Pending set = mip & mie, qualified by mstatus.MIE. Among pending lines, the lowest index wins.
- FSM states: IDLE, TRAP, RET. All three are encoded with the registered signal `redirect_valid`, which is 1 in TRAP and RET.
- In IDLE, priority is: exc_valid, then mret_i, then (pending interrupt and irq_allow).
- Exception entry:
  - mepc←exc_pc, mcause←{0,exc_cause}, mtval←exc_tval.
  - MPIE←MIE, MIE←0.
  - redirect_pc←{mtvec[31:2],2'b00}; go to TRAP.
- Interrupt entry:
  - mepc←commit_pc, mcause←{1,16+k}, mtval←0.
  - MPIE←MIE, MIE←0.
  - redirect_pc←base, or base+4·(16+k) when mtvec mode is 1 and VECTORED=1.
  - irq_taken←1 for one cycle; go to TRAP.
- mret:
  - MIE←MPIE, MPIE←1.
  - redirect_pc←mepc, or csr_wdata&~3 if the same cycle writes mepc; go to RET.
- TRAP/RET: hold redirect_valid and redirect_pc stable until redirect_ready; return to IDLE on the handshake edge.
- In TRAP/RET, exc_valid and mret_i are ignored; no interrupt is taken.
- A CSR write in the same cycle as a trap entry lands, except that trap updates override writes to mepc, mcause, mtval and mstatus.
- Counters are 64-bit and wrap modulo 2^64:
  - mcycle increments by 1 every cycle.
  - minstret increments by retire_cnt every cycle.
  - A write to either half replaces that half and suppresses that counter's increment for that cycle.

## Timing
- Reset: all outputs 0; mstatus, mie, mip, mepc, mcause, mtval, mscratch and counters = 0; mtvec = RESET_VEC; state IDLE.
- Assertion of rst_n mid-redirect drops redirect_valid asynchronously.
- irq_i rising before edge E1 sets mip at E1; trap decided at E2 (if enabled and irq_allow); redirect_valid and irq_taken high after E2.
- An exception or mret presented at edge E is visible as redirect_valid after E. Minimum trap-to-IDLE time is 1 cycle when redirect_ready is already high.
- CSR write at edge E is visible on csr_rd_data after E.

## Test plan
- Exception with mtvec=0x100, exc_cause=2, exc_pc=0x40, MIE=1 → redirect 0x100; mepc=0x40; mcause=2; MIE=0, MPIE=1. Hold redirect_ready=0 for 3 cycles → redirect_valid and redirect_pc stable throughout.
- NUM_IRQ=2, mie=0x30000, MIE=1, mtvec=0x201 (vectored), irq_i=2'b11, irq_allow=1 → line 0 wins; redirect to 0x240 two edges after irq_i rises; mcause=0x80000010; irq_taken pulses once.
- Same cycle exc_valid, mret_i and pending interrupt → exception taken. Then mret in IDLE → MIE←MPIE and redirect to mepc.
- mret in the same cycle as a csr write of 0x1237 to mepc → redirect_pc=0x1234.
- minstret=0xFFFF_FFFF_FFFF_FFFF with retire_cnt=2 → next value 1. Write 0x5 to mcycle → reads 0x5 the next cycle, then increments by 1 per cycle.
- Interrupt pending with irq_allow=0 → no trap. Reset asserted while in TRAP → redirect_valid=0 immediately; mtvec returns to RESET_VEC.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap sequencer: trap CSRs, 64-bit counters, interrupt latching
// and a registered, handshaked fetch redirect for exceptions, interrupts and mret.
module csr_trap_ctrl #(
    parameter int unsigned NUM_IRQ   = 2,
    parameter int unsigned RETIRE_W  = 2,
    parameter bit          VECTORED  = 1'b1,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IRQ-1:0]            irq_i,
    input  logic                          irq_allow,
    input  logic [31:0]                   commit_pc,
    input  logic [11:0]                   csr_rd_addr,
    output logic [31:0]                   csr_rd_data,
    input  logic                          csr_we,
    input  logic [11:0]                   csr_waddr,
    input  logic [31:0]                   csr_wdata,
    input  logic [$clog2(RETIRE_W+1)-1:0] retire_cnt,
    input  logic                          exc_valid,
    input  logic [3:0]                    exc_cause,
    input  logic [31:0]                   exc_pc,
    input  logic [31:0]                   exc_tval,
    input  logic                          mret_i,
    output logic                          redirect_valid,
    output logic [31:0]                   redirect_pc,
    input  logic                          redirect_ready,
    output logic                          irq_taken
);
    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMtval    = 12'h343;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMinstret = 12'hB02;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrMinstrh  = 12'hB82;
    localparam logic [31:0] PcMask       = 32'hFFFF_FFFC;
    localparam logic [31:0] MtvecRst     = VECTORED ? RESET_VEC : (RESET_VEC & PcMask);

    // Bit 0 of the encoding is the registered redirect_valid
    typedef enum logic [1:0] {StIdle = 2'b00, StTrap = 2'b01, StRet = 2'b11} state_e;
    state_e state_q, state_d;

    logic               mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
    logic [NUM_IRQ-1:0] mie_q, mie_d, mip_q;
    logic [31:0]        mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]        mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               irq_taken_q, irq_taken_d;

    logic [NUM_IRQ-1:0] pending;
    logic               irq_pend;
    logic [3:0]         irq_idx;
    logic               take_exc, take_mret, take_irq;
    logic [31:0]        mtvec_base, irq_target, mret_target;
    logic               wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
    logic               wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

    assign wr_mstatus   = csr_we && (csr_waddr == AddrMstatus);
    assign wr_mie       = csr_we && (csr_waddr == AddrMie);
    assign wr_mtvec     = csr_we && (csr_waddr == AddrMtvec);
    assign wr_mscratch  = csr_we && (csr_waddr == AddrMscratch);
    assign wr_mepc      = csr_we && (csr_waddr == AddrMepc);
    assign wr_mcause    = csr_we && (csr_waddr == AddrMcause);
    assign wr_mtval     = csr_we && (csr_waddr == AddrMtval);
    assign wr_mcycle    = csr_we && (csr_waddr == AddrMcycle);
    assign wr_mcycleh   = csr_we && (csr_waddr == AddrMcycleh);
    assign wr_minstret  = csr_we && (csr_waddr == AddrMinstret);
    assign wr_minstreth = csr_we && (csr_waddr == AddrMinstrh);

    assign pending = mip_q & mie_q & {NUM_IRQ{mstatus_mie_q}};

    // Lowest pending line wins
    always_comb begin
        irq_pend = |pending;
        irq_idx  = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) irq_idx = 4'(i);
        end
    end

    assign take_exc    = (state_q == StIdle) && exc_valid;
    assign take_mret   = (state_q == StIdle) && !exc_valid && mret_i;
    assign take_irq    = (state_q == StIdle) && !exc_valid && !mret_i && irq_pend && irq_allow;
    assign mtvec_base  = mtvec_q & PcMask;
    assign irq_target  = (VECTORED && mtvec_q[1:0] == 2'b01) ?
                         mtvec_base + {25'd0, 1'b1, irq_idx, 2'b00} : mtvec_base;
    assign mret_target = wr_mepc ? (csr_wdata & PcMask) : mepc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_exc || take_irq) state_d = StTrap;
                else if (take_mret)       state_d = StRet;
            end
            StTrap, StRet: if (redirect_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        redirect_valid = state_q[0];
        redirect_pc    = redirect_pc_q;
        irq_taken      = irq_taken_q;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        redirect_pc_d  = redirect_pc_q;
        irq_taken_d    = take_irq;

        if (wr_mstatus) begin
            mstatus_mie_d  = csr_wdata[3];
            mstatus_mpie_d = csr_wdata[7];
        end
        if (wr_mie)      mie_d      = csr_wdata[16 +: NUM_IRQ];
        if (wr_mtvec)    mtvec_d    = VECTORED ? csr_wdata : (csr_wdata & PcMask);
        if (wr_mscratch) mscratch_d = csr_wdata;
        if (wr_mepc)     mepc_d     = csr_wdata & PcMask;
        if (wr_mcause)   mcause_d   = csr_wdata;
        if (wr_mtval)    mtval_d    = csr_wdata;

        // Trap and mret side effects take precedence over a same-cycle CSR write
        if (take_exc) begin
            mepc_d         = exc_pc & PcMask;
            mcause_d       = {28'd0, exc_cause};
            mtval_d        = exc_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redirect_pc_d  = mtvec_base;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
            redirect_pc_d  = mret_target;
        end else if (take_irq) begin
            mepc_d         = commit_pc & PcMask;
            mcause_d       = {1'b1, 26'd0, 1'b1, irq_idx};
            mtval_d        = '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            redirect_pc_d  = irq_target;
        end

        if (wr_mcycle)       mcycle_d = {mcycle_q[63:32], csr_wdata};
        else if (wr_mcycleh) mcycle_d = {csr_wdata, mcycle_q[31:0]};
        else                 mcycle_d = mcycle_q + 64'd1;
        if (wr_minstret)       minstret_d = {minstret_q[63:32], csr_wdata};
        else if (wr_minstreth) minstret_d = {csr_wdata, minstret_q[31:0]};
        else                   minstret_d = minstret_q + 64'(retire_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MtvecRst;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            redirect_pc_q  <= '0;
            irq_taken_q    <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= irq_i;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            redirect_pc_q  <= redirect_pc_d;
            irq_taken_q    <= irq_taken_d;
        end
    end

    always_comb begin
        csr_rd_data = '0;
        case (csr_rd_addr)
            AddrMstatus: begin
                csr_rd_data[3] = mstatus_mie_q;
                csr_rd_data[7] = mstatus_mpie_q;
            end
            AddrMie:      csr_rd_data[16 +: NUM_IRQ] = mie_q;
            AddrMip:      csr_rd_data[16 +: NUM_IRQ] = mip_q;
            AddrMtvec:    csr_rd_data = mtvec_q;
            AddrMscratch: csr_rd_data = mscratch_q;
            AddrMepc:     csr_rd_data = mepc_q;
            AddrMcause:   csr_rd_data = mcause_q;
            AddrMtval:    csr_rd_data = mtval_q;
            AddrMcycle:   csr_rd_data = mcycle_q[31:0];
            AddrMcycleh:  csr_rd_data = mcycle_q[63:32];
            AddrMinstret: csr_rd_data = minstret_q[31:0];
            AddrMinstrh:  csr_rd_data = minstret_q[63:32];
            default:      csr_rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed scenarios plus random traffic against a cycle-level
// behavioural model; expected redirects are queued and popped by an independent monitor.
module tb_csr_trap_ctrl;
    localparam int unsigned NUM_IRQ   = 2;
    localparam int unsigned RETIRE_W  = 2;
    localparam bit          VECTORED  = 1'b1;
    localparam logic [31:0] RESET_VEC = 32'h0000_1000;
    localparam int          RCW       = $clog2(RETIRE_W + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_IRQ-1:0] irq_i = '0;
    logic               irq_allow = 1'b0;
    logic [31:0]        commit_pc = '0;
    logic [11:0]        csr_rd_addr = '0;
    logic [31:0]        csr_rd_data;
    logic               csr_we = 1'b0;
    logic [11:0]        csr_waddr = '0;
    logic [31:0]        csr_wdata = '0;
    logic [RCW-1:0]     retire_cnt = '0;
    logic               exc_valid = 1'b0;
    logic [3:0]         exc_cause = '0;
    logic [31:0]        exc_pc = '0;
    logic [31:0]        exc_tval = '0;
    logic               mret_i = 1'b0;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               redirect_ready = 1'b1;
    logic               irq_taken;

    always #5 clk = ~clk;

    csr_trap_ctrl #(
        .NUM_IRQ(NUM_IRQ), .RETIRE_W(RETIRE_W), .VECTORED(VECTORED), .RESET_VEC(RESET_VEC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .irq_allow(irq_allow), .commit_pc(commit_pc),
        .csr_rd_addr(csr_rd_addr), .csr_rd_data(csr_rd_data), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .retire_cnt(retire_cnt),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_i(mret_i), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .irq_taken(irq_taken)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit                m_mie, m_mpie, m_busy, m_irq_taken;
    bit [NUM_IRQ-1:0]  m_mie_r, m_mip;
    logic [31:0]       m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    longint unsigned   m_cyc, m_ret;
    logic [31:0]       exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] r;
        case (a)
            12'h300: r = (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h304: r = 32'(m_mie_r) << 16;
            12'h344: r = 32'(m_mip) << 16;
            12'h305: r = VECTORED ? m_mtvec : (m_mtvec & ~32'd3);
            12'h340: r = m_mscratch;
            12'h341: r = m_mepc;
            12'h342: r = m_mcause;
            12'h343: r = m_mtval;
            12'hB00: r = 32'(m_cyc);
            12'hB80: r = 32'(m_cyc >> 32);
            12'hB02: r = 32'(m_ret);
            12'hB82: r = 32'(m_ret >> 32);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_busy = 0; m_irq_taken = 0;
        m_mie_r = '0; m_mip = '0;
        m_mtvec = RESET_VEC; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
        m_cyc = 0; m_ret = 0;
        exp_q.delete();
    endtask

    // One clock of architectural behaviour, from the values present at the edge
    task automatic model_step();
        int  k = -1;
        bit  old_mie = m_mie;
        bit  old_mpie = m_mpie;
        bit  t_exc, t_mret, t_irq;
        logic [31:0] base = m_mtvec & ~32'd3;
        for (int i = 0; i < int'(NUM_IRQ); i++)
            if (k < 0 && m_mip[i] && m_mie_r[i] && m_mie) k = i;
        t_exc  = !m_busy && exc_valid;
        t_mret = !m_busy && !exc_valid && mret_i;
        t_irq  = !m_busy && !exc_valid && !mret_i && irq_allow && k >= 0;

        if (csr_we && csr_waddr == 12'hB00)
            m_cyc = (m_cyc & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
        else if (csr_we && csr_waddr == 12'hB80)
            m_cyc = (m_cyc & 64'h0000_0000_FFFF_FFFF) | (64'(csr_wdata) << 32);
        else
            m_cyc = m_cyc + 1;
        if (csr_we && csr_waddr == 12'hB02)
            m_ret = (m_ret & 64'hFFFF_FFFF_0000_0000) | 64'(csr_wdata);
        else if (csr_we && csr_waddr == 12'hB82)
            m_ret = (m_ret & 64'h0000_0000_FFFF_FFFF) | (64'(csr_wdata) << 32);
        else
            m_ret = m_ret + 64'(retire_cnt);

        if (csr_we) begin
            case (csr_waddr)
                12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_mie_r = csr_wdata[17:16];
                12'h305: m_mtvec = VECTORED ? csr_wdata : (csr_wdata & ~32'd3);
                12'h340: m_mscratch = csr_wdata;
                12'h341: m_mepc = csr_wdata & ~32'd3;
                12'h342: m_mcause = csr_wdata;
                12'h343: m_mtval = csr_wdata;
                default: ;
            endcase
        end

        m_irq_taken = 0;
        if (m_busy) begin
            if (redirect_ready) m_busy = 0;
        end else if (t_exc) begin
            m_mepc = exc_pc & ~32'd3; m_mcause = 32'(exc_cause); m_mtval = exc_tval;
            m_mpie = old_mie; m_mie = 0;
            exp_q.push_back(base);
            m_busy = 1;
        end else if (t_mret) begin
            m_mie = old_mpie; m_mpie = 1;
            exp_q.push_back(m_mepc);
            m_busy = 1;
        end else if (t_irq) begin
            m_mepc = commit_pc & ~32'd3; m_mcause = 32'h8000_0000 | 32'(16 + k); m_mtval = '0;
            m_mpie = old_mie; m_mie = 0;
            if (VECTORED && m_mtvec[1:0] == 2'b01) exp_q.push_back(base + 32'(4 * (16 + k)));
            else exp_q.push_back(base);
            m_irq_taken = 1;
            m_busy = 1;
        end
        m_mip = irq_i;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: compare outputs mid-cycle, pop the scoreboard on each redirect handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("redirect_valid", 32'(redirect_valid), 32'(m_busy));
                check("irq_taken", 32'(irq_taken), 32'(m_irq_taken));
                check($sformatf("csr_rd_data[%h]", csr_rd_addr), csr_rd_data,
                      m_read(csr_rd_addr));
                if (redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL redirect_pc: got unexpected redirect to %h, expected none",
                                 redirect_pc);
                    end else begin
                        check("redirect_pc", redirect_pc, exp_q[0]);
                        if (redirect_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr_rd_addr = a;
        #1;
        check(name, csr_rd_data, exp);
    endtask

    logic [11:0] addrs[14] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                               12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h123, 12'h7C0};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset redirect_valid", 32'(redirect_valid), 32'd0);
        check("reset irq_taken", 32'(irq_taken), 32'd0);
        rd_chk("reset mtvec", 12'h305, RESET_VEC);
        tick();
        rst_n = 1'b1;
        rd_chk("reset mstatus", 12'h300, 32'h0);

        // Exception with a stalled front end
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'h77;
        redirect_ready = 0;
        tick();
        exc_valid = 0;
        check("exc redirect_valid", 32'(redirect_valid), 32'd1);
        check("exc redirect_pc", redirect_pc, 32'h100);
        rd_chk("exc mepc", 12'h341, 32'h40);
        rd_chk("exc mcause", 12'h342, 32'h2);
        rd_chk("exc mstatus", 12'h300, 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall redirect_valid", 32'(redirect_valid), 32'd1);
            check("stall redirect_pc", redirect_pc, 32'h100);
        end
        redirect_ready = 1;
        tick();
        check("exc done", 32'(redirect_valid), 32'd0);

        // Vectored interrupt, both lines raised: line 0 wins
        commit_pc = 32'h500;
        csr_write(12'h305, 32'h201);
        csr_write(12'h304, 32'h3_0000);
        csr_write(12'h300, 32'h8);
        irq_allow = 1; irq_i = 2'b11;
        tick();
        check("irq E1 redirect_valid", 32'(redirect_valid), 32'd0);
        tick();
        check("irq redirect_valid", 32'(redirect_valid), 32'd1);
        check("irq redirect_pc", redirect_pc, 32'h240);
        check("irq_taken pulse", 32'(irq_taken), 32'd1);
        rd_chk("irq mcause", 12'h342, 32'h8000_0010);
        rd_chk("irq mepc", 12'h341, 32'h500);
        tick();
        check("irq_taken once", 32'(irq_taken), 32'd0);
        irq_i = 2'b00; irq_allow = 0;

        // Exception, mret and interrupt together: exception wins
        irq_i = 2'b01;
        csr_write(12'h300, 32'h8);
        exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h80; mret_i = 1; irq_allow = 1;
        tick();
        exc_valid = 0; mret_i = 0; irq_allow = 0; irq_i = 2'b00;
        check("prio redirect_pc", redirect_pc, 32'h200);
        check("prio irq_taken", 32'(irq_taken), 32'd0);
        rd_chk("prio mcause", 12'h342, 32'h5);
        tick();
        mret_i = 1;
        tick();
        mret_i = 0;
        check("mret redirect_pc", redirect_pc, 32'h80);
        rd_chk("mret mstatus", 12'h300, 32'h88);
        tick();

        // mret with same-cycle mepc write
        csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h1237; mret_i = 1;
        tick();
        csr_we = 0; mret_i = 0;
        check("mret bypass redirect_pc", redirect_pc, 32'h1234);
        rd_chk("mret bypass mepc", 12'h341, 32'h1234);
        tick();

        // Counters
        csr_write(12'hB82, 32'hFFFF_FFFF);
        csr_write(12'hB02, 32'hFFFF_FFFF);
        retire_cnt = 2;
        tick();
        retire_cnt = 0;
        rd_chk("minstret wrap lo", 12'hB02, 32'h1);
        rd_chk("minstret wrap hi", 12'hB82, 32'h0);
        csr_write(12'hB00, 32'h5);
        rd_chk("mcycle write", 12'hB00, 32'h5);
        tick();
        rd_chk("mcycle incr", 12'hB00, 32'h6);

        // Interrupt blocked by irq_allow, then taken and cut short by reset
        irq_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no irq without allow", 32'(redirect_valid), 32'd0);
        end
        irq_allow = 1; redirect_ready = 0;
        tick();
        check("irq1 redirect_pc", redirect_pc, 32'h244);
        rd_chk("irq1 mcause", 12'h342, 32'h8000_0011);
        #1;
        rst_n = 0;
        #1;
        check("async reset redirect_valid", 32'(redirect_valid), 32'd0);
        rd_chk("reset mtvec again", 12'h305, RESET_VEC);
        irq_i = 2'b00; irq_allow = 0; redirect_ready = 1;
        tick();
        tick();
        rst_n = 1;
        rd_chk("post reset mstatus", 12'h300, 32'h0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            csr_we     = ($urandom_range(0, 7) == 0);
            csr_waddr  = addrs[$urandom_range(0, 13)];
            csr_wdata  = $urandom;
            exc_valid  = ($urandom_range(0, 15) == 0);
            exc_cause  = 4'($urandom);
            exc_pc     = $urandom;
            exc_tval   = $urandom;
            mret_i     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) irq_i = 2'($urandom);
            irq_allow      = 1'($urandom_range(0, 1));
            redirect_ready = ($urandom_range(0, 2) != 0);
            retire_cnt     = 2'($urandom_range(0, 2));
            commit_pc      = $urandom;
            csr_rd_addr    = addrs[$urandom_range(0, 13)];
            tick();
        end
        csr_we = 0; exc_valid = 0; mret_i = 0; irq_allow = 0; redirect_ready = 1;
        retire_cnt = 0;
        repeat (4) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
